// File: rtl/sdcard_ram_bridge.sv
// rtl/sdcard_ram_bridge.sv - loader-to-Avalon write bridge through a show-ahead word FIFO
// Optional feature macro: BRIDGE_WORD_COUNT_EN enables the words_written counter.
module sdcard_ram_bridge #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 25
) (
    input  logic              clk50,
    input  logic              reset,
    input  logic              ram_we,
    input  logic [ADDR_W-1:0] ram_address,
    input  logic [15:0]       ram_data,
    output logic              ram_op_begun,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_write,
    output logic [15:0]       avm_writedata,
    output logic [1:0]        avm_byteenable,
    input  logic              avm_waitrequest,
    output logic              bridge_idle,
    output logic [ADDR_W-1:0] words_written
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = ADDR_W + 16;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic {ACC_IDLE, ACC_ACK} acc_state_t;

    acc_state_t     state;
    acc_state_t     state_next;
    logic [EW-1:0]  mem [DEPTH];
    logic [PW-1:0]  wptr;
    logic [PW-1:0]  rptr;
    logic [CW-1:0]  fifo_count;
    logic           fifo_full;
    logic           push;
    logic           pop;
    logic [EW-1:0]  head;

    assign fifo_full = (fifo_count == FULL_COUNT);

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            state <= ACC_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The acknowledge state blocks a second capture of a request still held high.
    always_comb begin
        state_next = state;
        case (state)
            ACC_IDLE: if (ram_we && !fifo_full) state_next = ACC_ACK;
            ACC_ACK:  state_next = ACC_IDLE;
            default:  state_next = ACC_IDLE;
        endcase
    end

    always_comb begin
        ram_op_begun = 1'b0;
        push         = 1'b0;
        case (state)
            ACC_IDLE: push = ram_we && !fifo_full;
            ACC_ACK:  ram_op_begun = 1'b1;
            default:  ram_op_begun = 1'b0;
        endcase
    end

    assign avm_write      = (fifo_count != '0);
    assign pop            = avm_write && !avm_waitrequest;
    assign head           = mem[rptr];
    assign avm_address    = head[EW-1:16];
    assign avm_writedata  = head[15:0];
    assign avm_byteenable = 2'b11;
    assign bridge_idle    = (fifo_count == '0) && (state == ACC_IDLE);

    always_ff @(posedge clk50) begin
        if (push) begin
            mem[wptr] <= {ram_address, ram_data};
        end
    end

    // Pointers are exactly log2(DEPTH) wide, so increment wraps modulo DEPTH.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

`ifdef BRIDGE_WORD_COUNT_EN
    logic [ADDR_W-1:0] word_cnt;

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            word_cnt <= '0;
        end else if (pop) begin
            word_cnt <= word_cnt + ADDR_W'(1);
        end
    end

    assign words_written = word_cnt;
`else
    assign words_written = '0;
`endif

endmodule

// File: tb/tb_sdcard_ram_bridge.sv
// tb/tb_sdcard_ram_bridge.sv - self-checking bench for sdcard_ram_bridge with a write scoreboard
module tb_sdcard_ram_bridge;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 25;

    logic              clk50 = 1'b0;
    logic              reset;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_address;
    logic [15:0]       ram_data;
    logic              ram_op_begun;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_write;
    logic [15:0]       avm_writedata;
    logic [1:0]        avm_byteenable;
    logic              avm_waitrequest;
    logic              bridge_idle;
    logic [ADDR_W-1:0] words_written;

    sdcard_ram_bridge #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk50           (clk50),
        .reset           (reset),
        .ram_we          (ram_we),
        .ram_address     (ram_address),
        .ram_data        (ram_data),
        .ram_op_begun    (ram_op_begun),
        .avm_address     (avm_address),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_byteenable  (avm_byteenable),
        .avm_waitrequest (avm_waitrequest),
        .bridge_idle     (bridge_idle),
        .words_written   (words_written)
    );

    always #10 clk50 = ~clk50;

    int                    n_cmp = 0;
    int                    n_err = 0;
    int                    ack_count = 0;
    int                    peak = 0;
    logic [ADDR_W+15:0]    q[$];
    logic                  prev_ack = 1'b0;
    logic                  prev_stall = 1'b0;
    logic [ADDR_W-1:0]     prev_addr;
    logic [15:0]           prev_data;
    logic                  ack_saw_write;
    int                    ack_base;
    logic [ADDR_W-1:0]     exp_count_12;
    logic [ADDR_W-1:0]     exp_count_256;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk50);
        #1;
    endtask

    // Loader model: request held until the acknowledge is seen, then dropped.
    task automatic send(input logic [ADDR_W-1:0] a, input logic [15:0] d);
        bit got;
        got = 1'b0;
        ram_address = a;
        ram_data    = d;
        ram_we      = 1'b1;
        q.push_back({a, d});
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk50);
            if (ram_op_begun) begin
                got = 1'b1;
                ack_saw_write = avm_write;
            end
        end
        if (!got) chk("ack_timeout", 64'd0, 64'd1);
        tick();
        ram_we = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 400 && q.size() != 0; i++) tick();
        chk(tag, 64'(q.size()), 64'd0);
    endtask

    always @(negedge clk50) begin
        if (reset) begin
            prev_stall = 1'b0;
            prev_ack   = 1'b0;
        end else begin
            if (ram_op_begun) begin
                ack_count++;
                chk("ack_one_cycle", 64'(prev_ack), 64'd0);
            end
            prev_ack = ram_op_begun;
            if (int'(dut.fifo_count) > peak) peak = int'(dut.fifo_count);
            if (prev_stall && avm_write) begin
                chk("stall_addr_stable", 64'(avm_address), 64'(prev_addr));
                chk("stall_data_stable", 64'(avm_writedata), 64'(prev_data));
            end
            if (avm_write && !avm_waitrequest) begin
                if (q.size() == 0) begin
                    chk("unexpected_write", 64'(avm_address), 64'h1_0000_0000);
                end else begin
                    logic [ADDR_W+15:0] e;
                    e = q.pop_front();
                    chk("wr_addr", 64'(avm_address), 64'(e[ADDR_W+15:16]));
                    chk("wr_data", 64'(avm_writedata), 64'(e[15:0]));
                end
            end
            prev_stall = avm_write && avm_waitrequest;
            prev_addr  = avm_address;
            prev_data  = avm_writedata;
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef BRIDGE_WORD_COUNT_EN
        exp_count_12  = 25'd12;
        exp_count_256 = 25'd256;
`else
        exp_count_12  = 25'd0;
        exp_count_256 = 25'd0;
`endif
        reset = 1'b1;
        ram_we = 1'b0;
        ram_address = '0;
        ram_data = '0;
        avm_waitrequest = 1'b0;
        #5;
        chk("rst_op_begun", 64'(ram_op_begun), 64'd0);
        chk("rst_avm_write", 64'(avm_write), 64'd0);
        chk("rst_idle", 64'(bridge_idle), 64'd1);
        chk("rst_words", 64'(words_written), 64'd0);
        chk("byteenable", 64'(avm_byteenable), 64'd3);
        repeat (2) tick();
        reset = 1'b0;
        tick();

        // Single word: ack and write both visible in the cycle after the push.
        send(25'h000010, 16'hA55A);
        chk("single_write_with_ack", 64'(ack_saw_write), 64'd1);
        chk("single_ack_dropped", 64'(ram_op_begun), 64'd0);
        chk("single_idle", 64'(bridge_idle), 64'd1);
        chk("single_queue_empty", 64'(q.size()), 64'd0);

        // Request still high during the acknowledge cycle is captured once.
        peak = 0;
        ack_base = ack_count;
        send(25'h000020, 16'h1234);
        repeat (4) tick();
        chk("hold_ack_count", 64'(ack_count - ack_base), 64'd1);
        chk("hold_peak", 64'(peak), 64'd1);
        drain("hold_drain");

        // Stall: eight words fill the FIFO, ninth waits for the stall to end.
        ack_base = ack_count;
        fork
            begin
                avm_waitrequest = 1'b1;
                repeat (20) tick();
                chk("full_acks", 64'(ack_count - ack_base), 64'd8);
                chk("full_count", 64'(dut.fifo_count), 64'(DEPTH));
                chk("full_no_idle", 64'(bridge_idle), 64'd0);
                avm_waitrequest = 1'b0;
            end
            begin
                for (int i = 0; i < 10; i++)
                    send(ADDR_W'(32'h100 + i), 16'(16'hC000 + i * 16'h0101));
            end
        join
        drain("stall_drain");
        chk("stall_acks_total", 64'(ack_count - ack_base), 64'd10);
        chk("words_after_12", 64'(words_written), 64'(exp_count_12));

        // Reset with five words buffered discards them and drops avm_write at once.
        avm_waitrequest = 1'b1;
        for (int i = 0; i < 5; i++) send(ADDR_W'(32'h200 + i), 16'(16'h5000 + i));
        chk("pre_rst_write", 64'(avm_write), 64'd1);
        chk("pre_rst_count", 64'(dut.fifo_count), 64'd5);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_write", 64'(avm_write), 64'd0);
        chk("async_rst_idle", 64'(bridge_idle), 64'd1);
        chk("async_rst_words", 64'(words_written), 64'd0);
        q.delete();
        repeat (2) tick();
        reset = 1'b0;
        avm_waitrequest = 1'b0;
        repeat (10) tick();
        chk("post_rst_no_write", 64'(avm_write), 64'd0);

        // Continuous stream of 256 words with no stall.
        peak = 0;
        for (int i = 0; i < 256; i++) send(ADDR_W'(i), 16'(i * 7 + 3));
        drain("stream_drain");
        chk("stream_peak", 64'(peak), 64'd1);
        chk("stream_words", 64'(words_written), 64'(exp_count_256));
        chk("stream_idle", 64'(bridge_idle), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
